spawn_arbiter: RTL
==================

SPAWN_ARBITER -- requirements
Module: spawn_arbiter

Interface
REQ-001 Parameter PROC_CNT, default 4: number of processors requesting spawns; SHALL be >= 2.
REQ-002 Parameter ADDR_W, default 8: width of the task start address.
REQ-003 Parameter STALL_MAX, default 255: consecutive full-stall cycles that trip overflow_err; SHALL be >= 1.
REQ-004 Ports: clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 Ports: reset  in  1  synchronous, active-high reset.
REQ-006 Ports: spawn_req  in  PROC_CNT  bit i = processor i requests a spawn.
REQ-007 Ports: spawn_addr  in  PROC_CNT*ADDR_W  slice i = start address from processor i; slice i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 Ports: spawn_ack  out  PROC_CNT  one-hot, one-cycle pulse; bit i = processor i's address was written.
REQ-009 Ports: q_wrreq  out  1  task-queue write strobe.
REQ-010 Ports: q_data  out  ADDR_W  task-queue write data.
REQ-011 Ports: q_full  in  1  task queue full.
REQ-012 Ports: grant_idx  out  clog2(PROC_CNT)  index of the last granted processor.
REQ-013 Ports: overflow_err  out  1  sticky flag: queue stayed full too long.
REQ-014 Ports: busy  out  1  high while any spawn_req bit is set or the FSM is in HOLD.

Function
REQ-015 All outputs SHALL be registered; busy is the sole exception and SHALL be combinational.
REQ-016 FSM states SHALL be IDLE and HOLD; HOLD SHALL last exactly one cycle and return to IDLE.
REQ-017 IDLE with any spawn_req bit set and q_full=0: the block SHALL grant the lowest index j at or after rr_ptr, taken cyclically (modulo PROC_CNT).
REQ-018 Grant cycle: the next edge SHALL set q_wrreq=1, q_data=spawn_addr slice j, spawn_ack=one-hot(j), grant_idx=j, rr_ptr=(j+1) mod PROC_CNT, and state=HOLD.
REQ-019 HOLD: q_wrreq and spawn_ack SHALL be 0 and no grant SHALL occur, so a requester dropping its req after the ack is never re-granted; peak throughput is one write per 2 cycles.
REQ-020 Requester rule: spawn_req[i] and its address slice SHALL stay stable until spawn_ack[i]; the block samples the address only in the grant cycle.
REQ-021 q_full=1 in IDLE: no grant, q_wrreq=0 and rr_ptr unchanged; q_full is sampled only in IDLE.
REQ-022 Stall counter (clog2(STALL_MAX+1) bits): SHALL increment each IDLE cycle with a request pending and q_full=1, saturating at STALL_MAX.
REQ-023 The stall counter SHALL clear on any grant and on any IDLE cycle with no request pending.
REQ-024 When the stall counter reaches STALL_MAX, overflow_err SHALL be set; it SHALL clear only on reset.
REQ-025 A new request arriving during HOLD SHALL be considered in the following IDLE cycle.
REQ-026 rr_ptr wrap-around: after granting index PROC_CNT-1, the search SHALL start at index 0.
REQ-027 Reset mid-operation: any in-flight q_wrreq or spawn_ack SHALL be 0 after the reset edge; unacknowledged requests are not lost, because requesters still hold them.

Reset
REQ-028 While reset=1 at an edge: state=IDLE, rr_ptr=0, stall counter=0, q_wrreq=0, q_data=0, spawn_ack=0, grant_idx=0, overflow_err=0.
REQ-029 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-030 Single request: PROC_CNT=4, spawn_req=0010, addr1=0x3C, q_full=0 -> q_wrreq pulse with q_data=0x3C, spawn_ack=0010, grant_idx=1, one HOLD cycle, then idle.
REQ-031 Round-robin fairness: all four requests held continuously -> grants in order 0,1,2,3,0, with q_wrreq high every second cycle.
REQ-032 Wrap and priority: rr_ptr=3 with requests 1001 -> grant 3 first, then 0.
REQ-033 Full stall: q_full=1 with a request pending for 255 cycles -> no q_wrreq; overflow_err rises on the cycle the stall counter hits 255 and stays high after q_full drops and grants resume.
REQ-034 Reset mid-grant: reset asserted in the grant cycle -> next edge q_wrreq=0, spawn_ack=0, rr_ptr=0; the held request is granted after reset is released.
REQ-035 Late request: a request rising during HOLD -> granted on the first IDLE cycle after HOLD, provided q_full=0.

Source files
------------

// File: rtl/spawn_arbiter.sv
// spawn_arbiter
//   Round-robin arbiter that collects spawn requests from PROC_CNT processors
//   and writes the winning start address into a task queue. A two-state FSM
//   (IDLE -> HOLD -> IDLE) spaces writes one cycle apart so that a requester
//   dropping its request after its ack can never be granted a second time.
//   A stall counter watches how long the queue stays full while work is
//   pending and raises a sticky overflow_err once it hits STALL_MAX.
//
// Ports
//   clock        in   sole clock, rising edge
//   reset        in   synchronous, active-high
//   spawn_req    in   [PROC_CNT]        per-processor spawn request
//   spawn_addr   in   [PROC_CNT*ADDR_W] slice i = start address of processor i
//   spawn_ack    out  [PROC_CNT]        one-hot, one-cycle write acknowledge
//   q_wrreq      out  task-queue write strobe
//   q_data       out  [ADDR_W]          task-queue write data
//   q_full       in   task queue full
//   grant_idx    out  [clog2(PROC_CNT)] index of the last granted processor
//   overflow_err out  sticky: queue stayed full for STALL_MAX cycles
//   busy         out  combinational: any request pending or FSM in HOLD

module spawn_arbiter #(
   parameter int PROC_CNT  = 4,
   parameter int ADDR_W    = 8,
   parameter int STALL_MAX = 255
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [PROC_CNT-1:0]           spawn_req,
   input  logic [PROC_CNT*ADDR_W-1:0]    spawn_addr,
   output logic [PROC_CNT-1:0]           spawn_ack,
   output logic                          q_wrreq,
   output logic [ADDR_W-1:0]             q_data,
   input  logic                          q_full,
   output logic [$clog2(PROC_CNT)-1:0]   grant_idx,
   output logic                          overflow_err,
   output logic                          busy
);

   localparam int IDX_W = $clog2(PROC_CNT);
   localparam int CNT_W = $clog2(STALL_MAX + 1);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]   stall_cnt;

   // Arbitration result for the current cycle
   logic               pick_vld;
   logic [IDX_W-1:0]   pick_idx;
   logic [ADDR_W-1:0]  pick_addr;
   logic [IDX_W-1:0]   next_ptr;
   logic               req_any;

   assign req_any = |spawn_req;

   // Cyclic search: offset 0 is rr_ptr itself, so the first hit is the
   // lowest index at or after rr_ptr, wrapping modulo PROC_CNT.
   always_comb begin
      int j;
      pick_vld = 1'b0;
      pick_idx = '0;
      j        = 0;
      for (int k = 0; k < PROC_CNT; k++) begin
         j = (int'(rr_ptr) + k) % PROC_CNT;
         if (!pick_vld && spawn_req[j]) begin
            pick_vld = 1'b1;
            pick_idx = IDX_W'(j);
         end
      end
   end

   assign pick_addr = spawn_addr[pick_idx*ADDR_W +: ADDR_W];

   // PROC_CNT need not be a power of two, so wrap explicitly
   assign next_ptr = (pick_idx == IDX_W'(PROC_CNT - 1)) ? '0 : pick_idx + 1'b1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         stall_cnt    <= '0;
         q_wrreq      <= 1'b0;
         q_data       <= '0;
         spawn_ack    <= '0;
         grant_idx    <= '0;
         overflow_err <= 1'b0;
      end else begin
         // Strobes are single-cycle pulses; only a grant raises them
         q_wrreq   <= 1'b0;
         spawn_ack <= '0;
         case (state)
            IDLE: begin
               if (req_any) begin
                  if (!q_full && pick_vld) begin
                     q_wrreq   <= 1'b1;
                     q_data    <= pick_addr;
                     spawn_ack <= PROC_CNT'(1) << pick_idx;
                     grant_idx <= pick_idx;
                     rr_ptr    <= next_ptr;
                     stall_cnt <= '0;
                     state     <= HOLD;
                  end else begin
                     if (stall_cnt < CNT_W'(STALL_MAX))
                        stall_cnt <= stall_cnt + 1'b1;
                     // Flag on the same edge the counter reaches STALL_MAX
                     if (stall_cnt >= CNT_W'(STALL_MAX - 1))
                        overflow_err <= 1'b1;
                  end
               end else begin
                  stall_cnt <= '0;
               end
            end
            HOLD: begin
               // Dead cycle: lets the acked requester drop its request
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = req_any | (state == HOLD);

endmodule
